// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// Holds the default counter width, the post-reset divisor/high-time,
// and the legality rule applied to every configuration load.
package clk_div_pkg;

  // Default counter width and post-reset configuration
  localparam int CNT_W_DEF = 8;
  localparam int DIV_DEF   = 5;
  localparam int HI_DEF    = 2;

  // Width the legality helper works at; callers zero-extend into it so the
  // same function serves any CNT_W up to 32 bits.
  localparam int CFG_MAX_W = 32;

  // A configuration is usable when the period is at least two cycles and the
  // high time leaves at least one low cycle: div >= 2 and 1 <= hi < div.
  function automatic logic cfg_legal(input logic [CFG_MAX_W-1:0] div,
                                     input logic [CFG_MAX_W-1:0] hi);
    logic div_ok;
    logic hi_ok;
    div_ok = (div >= CFG_MAX_W'(2));
    hi_ok  = (hi >= CFG_MAX_W'(1)) && (hi < div);
    return div_ok && hi_ok;
  endfunction

endpackage : clk_div_pkg

// File: rtl/clock_div_prog_if.sv
// Control and status bundle of the programmable clock divider.
// The master side (the controlling logic) drives enable and configuration
// loads; the slave side (the divider) returns the divided clock and the
// one-cycle status pulses.
interface clock_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic [CNT_W-1:0] hi_in;
  logic             load;
  logic             clk_out;
  logic             tick;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output en,
    output div_in,
    output hi_in,
    output load,
    input  clk_out,
    input  tick,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  en,
    input  div_in,
    input  hi_in,
    input  load,
    output clk_out,
    output tick,
    output cfg_ack,
    output cfg_err
  );

endinterface : clock_div_prog_if

// File: rtl/clk_div_cfg.sv
// Configuration block of the programmable clock divider.
// Validates load requests, keeps the staged (shadow) divisor/high time and
// the pending flag, and swaps the shadow into the active registers when the
// phase counter signals an apply. Raises one-cycle ack/err pulses.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEF,
  parameter int HI_DEFAULT  = HI_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] hi_i,
  input  logic             apply_i,
  output logic [CNT_W-1:0] div_act_o,
  output logic [CNT_W-1:0] hi_act_o,
  output logic             pend_o,
  output logic             cfg_ack_o,
  output logic             cfg_err_o
);

  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] hi_act_q,  hi_act_d;
  logic [CNT_W-1:0] div_shd_q, div_shd_d;
  logic [CNT_W-1:0] hi_shd_q,  hi_shd_d;
  logic             pend_q,    pend_d;
  logic             ack_q,     ack_d;
  logic             err_q,     err_d;

  logic load_legal;
  logic accept;
  logic reject;
  logic apply_eff;

  assign load_legal = cfg_legal(CFG_MAX_W'(div_i), CFG_MAX_W'(hi_i));
  assign accept     = load_i & load_legal;
  assign reject     = load_i & ~load_legal;
  // Only a staged configuration can ever be applied.
  assign apply_eff  = apply_i & pend_q;

  // Next-state: apply uses the shadow as it stood before this edge, so a load
  // arriving on the apply edge is staged for the following boundary instead.
  always_comb begin
    div_act_d = div_act_q;
    hi_act_d  = hi_act_q;
    div_shd_d = div_shd_q;
    hi_shd_d  = hi_shd_q;
    pend_d    = pend_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (apply_eff) begin
      div_act_d = div_shd_q;
      hi_act_d  = hi_shd_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end

    if (accept) begin
      div_shd_d = div_i;
      hi_shd_d  = hi_i;
      pend_d    = 1'b1;
    end

    if (reject) begin
      err_d = 1'b1;
    end
  end

  // Configuration state; reset restores defaults and drops anything pending.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_act_q <= CNT_W'(DIV_DEFAULT);
      hi_act_q  <= CNT_W'(HI_DEFAULT);
      div_shd_q <= CNT_W'(DIV_DEFAULT);
      hi_shd_q  <= CNT_W'(HI_DEFAULT);
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      div_act_q <= div_act_d;
      hi_act_q  <= hi_act_d;
      div_shd_q <= div_shd_d;
      hi_shd_q  <= hi_shd_d;
      pend_q    <= pend_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign div_act_o = div_act_q;
  assign hi_act_o  = hi_act_q;
  assign pend_o    = pend_q;
  assign cfg_ack_o = ack_q;
  assign cfg_err_o = err_q;

endmodule : clk_div_cfg

// File: rtl/clock_div_prog.sv
// Runtime-programmable integer clock divider.
// A phase counter runs from 0 to div_act-1; the registered output is high
// while the pre-increment phase is below hi_act. New settings are applied
// only at the end of a period (or immediately while disabled) so the output
// never glitches. A one-cycle tick marks every period start.
module clock_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEF,
  parameter int HI_DEFAULT  = HI_DEF
) (
  input  logic            clk_in,
  input  logic            rst,
  clock_div_prog_if.slave bus
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q,    tick_d;

  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] hi_act;
  logic             pend;
  logic             cfg_ack;
  logic             cfg_err;
  logic             wrap;
  logic             apply;

  clk_div_cfg #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .HI_DEFAULT  (HI_DEFAULT)
  ) u_cfg (
    .clk_in    (clk_in),
    .rst       (rst),
    .load_i    (bus.load),
    .div_i     (bus.div_in),
    .hi_i      (bus.hi_in),
    .apply_i   (apply),
    .div_act_o (div_act),
    .hi_act_o  (hi_act),
    .pend_o    (pend),
    .cfg_ack_o (cfg_ack),
    .cfg_err_o (cfg_err)
  );

  // Last phase of the current period under the active divisor.
  assign wrap = (count_q == (div_act - CNT_W'(1)));

  // Running: swap configs only at the period boundary. Stopped: the output is
  // already parked low, so a staged config can be taken on the next edge.
  assign apply = pend & (bus.en ? wrap : 1'b1);

  // Next phase and output levels, all derived from the pre-increment phase.
  always_comb begin
    count_d   = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    if (bus.en) begin
      count_d   = wrap ? '0 : (count_q + CNT_W'(1));
      clk_out_d = (count_q < hi_act);
      tick_d    = (count_q == '0);
    end
  end

  // Phase counter and registered outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.cfg_ack = cfg_ack;
  assign bus.cfg_err = cfg_err;

endmodule : clock_div_prog
